hough_vote_scheduler: RTL and testbench



---
 rtl/hough_vote_scheduler.sv | 100 ++++++++++
 tb/tb_hough_vote_scheduler.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/hough_vote_scheduler.sv
// Hough voting sequencer: pops edge points from the point FIFO and issues one
// vote request per theta bin to the accumulator datapath over valid/ready.
module hough_vote_scheduler #(
   parameter int unsigned DATA_WIDTH  = 21,
   parameter int unsigned COORD_WIDTH = 10,
   parameter int unsigned N_THETA     = 180,
   parameter int unsigned THETA_WIDTH = $clog2(N_THETA),
   parameter int unsigned CNT_WIDTH   = 16
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   start,
   input  logic                   fifo_empty,
   output logic                   fifo_rd_en,
   input  logic [DATA_WIDTH-1:0]  fifo_rd_data,
   output logic                   vote_valid,
   input  logic                   vote_ready,
   output logic [COORD_WIDTH-1:0] vote_x,
   output logic [COORD_WIDTH-1:0] vote_y,
   output logic [THETA_WIDTH-1:0] vote_theta,
   output logic                   vote_last,
   output logic                   busy,
   output logic                   done,
   output logic [CNT_WIDTH-1:0]   point_count
);

   typedef enum logic [2:0] {StIdle, StPop, StLoad, StSweep, StDone} state_e;

   state_e state_q;
   logic   last_q;
   logic   theta_final;
   logic   theta_penult;

   assign fifo_rd_en   = (state_q == StPop) && !fifo_empty;
   assign theta_final  = (vote_theta == THETA_WIDTH'(N_THETA - 1));
   assign theta_penult = (vote_theta == THETA_WIDTH'(N_THETA - 2));

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= StIdle;
         last_q      <= 1'b0;
         vote_valid  <= 1'b0;
         vote_x      <= '0;
         vote_y      <= '0;
         vote_theta  <= '0;
         vote_last   <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         point_count <= '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (start) begin
                  point_count <= '0;
                  busy        <= 1'b1;
                  state_q     <= StPop;
               end
            end
            StPop: begin
               if (fifo_rd_en) state_q <= StLoad;
            end
            StLoad: begin
               // Read data is registered in the FIFO, so it is valid only now.
               vote_x      <= fifo_rd_data[COORD_WIDTH-1:0];
               vote_y      <= fifo_rd_data[2*COORD_WIDTH-1:COORD_WIDTH];
               last_q      <= fifo_rd_data[DATA_WIDTH-1];
               vote_theta  <= '0;
               vote_last   <= 1'b0;
               vote_valid  <= 1'b1;
               point_count <= point_count + CNT_WIDTH'(1);
               state_q     <= StSweep;
            end
            StSweep: begin
               if (vote_ready) begin
                  if (theta_final) begin
                     vote_valid <= 1'b0;
                     vote_last  <= 1'b0;
                     if (last_q) begin
                        done    <= 1'b1;
                        state_q <= StDone;
                     end else begin
                        state_q <= StPop;
                     end
                  end else begin
                     vote_theta <= vote_theta + THETA_WIDTH'(1);
                     vote_last  <= last_q && theta_penult;
                  end
               end
            end
            StDone: begin
               done    <= 1'b0;
               busy    <= 1'b0;
               state_q <= StIdle;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_hough_vote_scheduler.sv
// Directed bench for hough_vote_scheduler with N_THETA=4 and a registered-read FIFO model.
module tb_hough_vote_scheduler;

   localparam int NT = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic        fifo_empty;
   logic        fifo_rd_en;
   logic [20:0] fifo_rd_data = '0;
   logic        vote_valid;
   logic        vote_ready;
   logic [9:0]  vote_x;
   logic [9:0]  vote_y;
   logic [1:0]  vote_theta;
   logic        vote_last;
   logic        busy;
   logic        done;
   logic [15:0] point_count;

   int total = 0;
   int bad   = 0;

   logic [20:0] mem [0:31];
   int          wptr = 0;
   int          rptr = 0;
   logic        wr_en = 1'b0;
   logic [20:0] wr_data = '0;

   always #5 clk = ~clk;

   hough_vote_scheduler #(
      .DATA_WIDTH (21),
      .COORD_WIDTH(10),
      .N_THETA    (NT),
      .THETA_WIDTH(2),
      .CNT_WIDTH  (16)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .fifo_empty  (fifo_empty),
      .fifo_rd_en  (fifo_rd_en),
      .fifo_rd_data(fifo_rd_data),
      .vote_valid  (vote_valid),
      .vote_ready  (vote_ready),
      .vote_x      (vote_x),
      .vote_y      (vote_y),
      .vote_theta  (vote_theta),
      .vote_last   (vote_last),
      .busy        (busy),
      .done        (done),
      .point_count (point_count)
   );

   // FIFO model: writes land on the edge, read data registered after accepted rd_en.
   assign fifo_empty = (wptr == rptr);
   always @(posedge clk) begin
      if (wr_en) begin
         mem[wptr % 32] <= wr_data;
         wptr <= wptr + 1;
      end
      if (fifo_rd_en && !fifo_empty) begin
         fifo_rd_data <= mem[rptr % 32];
         rptr <= rptr + 1;
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish (total=%0d bad=%0d)", total, bad);
      $fatal(1, "watchdog");
   end

   function automatic logic [20:0] ent(input logic l, input int y, input int x);
      return {l, 10'(y), 10'(x)};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   task automatic push(input logic [20:0] d);
      wr_en   = 1'b1;
      wr_data = d;
      step();
      wr_en   = 1'b0;
   endtask

   // Leaves the bench in cycle t1 of the new frame.
   task automatic begin_frame();
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   task automatic sweep4(input string tag, input int x, input int y, input logic l);
      for (int i = 0; i < NT; i++) begin
         step();
         chk({tag, "_valid"}, 32'(vote_valid), 32'd1);
         chk({tag, "_x"}, 32'(vote_x), 32'(x));
         chk({tag, "_y"}, 32'(vote_y), 32'(y));
         chk({tag, "_theta"}, 32'(vote_theta), 32'(i));
         chk({tag, "_last"}, 32'(vote_last), 32'(l && (i == NT - 1)));
      end
   endtask

   // Two-point frame {0,5,3},{1,7,2} with vote_ready=1; starts at t1, ends at t13.
   task automatic check_frame_std(input string tag, input int exp_pc);
      chk({tag, "_t1_rd"}, 32'(fifo_rd_en), 32'd1);
      chk({tag, "_t1_busy"}, 32'(busy), 32'd1);
      chk({tag, "_t1_valid"}, 32'(vote_valid), 32'd0);
      step();
      chk({tag, "_t2_rd"}, 32'(fifo_rd_en), 32'd0);
      chk({tag, "_t2_valid"}, 32'(vote_valid), 32'd0);
      sweep4({tag, "_p0"}, 3, 5, 1'b0);
      step();
      chk({tag, "_t7_rd"}, 32'(fifo_rd_en), 32'd1);
      chk({tag, "_t7_valid"}, 32'(vote_valid), 32'd0);
      step();
      chk({tag, "_t8_valid"}, 32'(vote_valid), 32'd0);
      sweep4({tag, "_p1"}, 2, 7, 1'b1);
      step();
      chk({tag, "_t13_done"}, 32'(done), 32'd1);
      chk({tag, "_t13_valid"}, 32'(vote_valid), 32'd0);
      chk({tag, "_t13_pc"}, 32'(point_count), 32'(exp_pc));
   endtask

   initial begin
      int eth;
      reset      = 1'b1;
      start      = 1'b0;
      vote_ready = 1'b0;
      step();
      step();
      chk("rst_valid", 32'(vote_valid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_pc", 32'(point_count), 32'd0);
      chk("rst_xy", 32'({vote_x, vote_y}), 32'd0);
      chk("rst_theta", 32'(vote_theta), 32'd0);
      chk("rst_last", 32'(vote_last), 32'd0);
      chk("rst_rd", 32'(fifo_rd_en), 32'd0);
      reset = 1'b0;

      // 1: basic two-point frame
      vote_ready = 1'b1;
      push(ent(1'b0, 5, 3));
      push(ent(1'b1, 7, 2));
      begin_frame();
      check_frame_std("s1", 2);
      step();
      chk("s1_t14_busy", 32'(busy), 32'd0);
      chk("s1_t14_done", 32'(done), 32'd0);

      // 2: backpressure, ready pattern 1,0,0,1,...
      push(ent(1'b1, 9, 4));
      begin_frame();
      chk("s2_rd", 32'(fifo_rd_en), 32'd1);
      step();
      step();
      eth = 0;
      for (int k = 0; k < 20 && eth < NT; k++) begin
         vote_ready = (k % 3 == 0);
         chk("s2_valid", 32'(vote_valid), 32'd1);
         chk("s2_theta", 32'(vote_theta), 32'(eth));
         chk("s2_xy", 32'({vote_x, vote_y}), 32'({10'd4, 10'd9}));
         chk("s2_last", 32'(vote_last), 32'(eth == NT - 1));
         if (vote_ready) eth++;
         step();
      end
      chk("s2_votes", 32'(eth), 32'(NT));
      chk("s2_done", 32'(done), 32'd1);
      vote_ready = 1'b1;
      step();
      chk("s2_idle", 32'(busy), 32'd0);

      // 3: empty-FIFO stall, entry written at t10
      begin_frame();
      for (int i = 1; i <= 9; i++) begin
         chk("s3_stall_rd", 32'(fifo_rd_en), 32'd0);
         chk("s3_stall_busy", 32'(busy), 32'd1);
         step();
      end
      chk("s3_t10_rd", 32'(fifo_rd_en), 32'd0);
      push(ent(1'b1, 1, 1));
      chk("s3_t11_rd", 32'(fifo_rd_en), 32'd1);
      step();
      sweep4("s3", 1, 1, 1'b1);
      step();
      chk("s3_done", 32'(done), 32'd1);
      chk("s3_pc", 32'(point_count), 32'd1);
      step();

      // 4: start pulse during SWEEP is ignored
      push(ent(1'b1, 4, 6));
      begin_frame();
      step();
      step();
      step();
      chk("s4_theta1", 32'(vote_theta), 32'd1);
      start = 1'b1;
      step();
      start = 1'b0;
      chk("s4_theta2", 32'(vote_theta), 32'd2);
      chk("s4_pc", 32'(point_count), 32'd1);
      chk("s4_busy", 32'(busy), 32'd1);
      step();
      chk("s4_last", 32'(vote_last), 32'd1);
      step();
      chk("s4_done", 32'(done), 32'd1);
      chk("s4_pc_end", 32'(point_count), 32'd1);
      step();
      chk("s4_idle", 32'(busy), 32'd0);

      // 5: reset mid-SWEEP with ready low at theta=2
      push(ent(1'b0, 3, 8));
      push(ent(1'b1, 6, 1));
      begin_frame();
      step();
      step();
      step();
      step();
      vote_ready = 1'b0;
      chk("s5_theta", 32'(vote_theta), 32'd2);
      reset = 1'b1;
      step();
      chk("s5_valid", 32'(vote_valid), 32'd0);
      chk("s5_busy", 32'(busy), 32'd0);
      chk("s5_pc", 32'(point_count), 32'd0);
      chk("s5_rd", 32'(fifo_rd_en), 32'd0);
      reset      = 1'b0;
      vote_ready = 1'b1;
      step();
      begin_frame();
      chk("s5_rd2", 32'(fifo_rd_en), 32'd1);
      step();
      sweep4("s5", 1, 6, 1'b1);
      step();
      chk("s5_done", 32'(done), 32'd1);
      chk("s5_pc2", 32'(point_count), 32'd1);
      step();

      // 6: back-to-back frames
      push(ent(1'b0, 5, 3));
      push(ent(1'b1, 7, 2));
      push(ent(1'b0, 5, 3));
      push(ent(1'b1, 7, 2));
      begin_frame();
      check_frame_std("s6a", 2);
      step();
      chk("s6_idle", 32'(busy), 32'd0);
      begin_frame();
      check_frame_std("s6b", 2);
      step();
      chk("s6_end", 32'(busy), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
